tick_scheduler: RTL
===================

// Module: tick_scheduler
// PURPOSE
//   Shares one prescaled timebase between N_CH independent software/RTL timers.
//   Derives a base tick enable from i_clk. Each channel counts a programmable number of base ticks.
//   Each channel then emits a one-cycle fire enable, either one-shot or periodic.
//   Fire outputs are clock enables in the i_clk domain, never clocks.
// PARAMETERS
//   I_CLK_FRQ  100_000_000  input clock frequency, Hz
//   TICK_FRQ   1_000        base tick rate, Hz; DIV = I_CLK_FRQ/TICK_FRQ, DIV >= 2
//   N_CH       4            number of timer channels, 1..16
//   PERIOD_W   16           width of per-channel period, in base ticks
// PORTS
//   i_clk         in   1                 system clock
//   i_rst         in   1                 reset, asynchronous, active-high
//   i_cfg_we      in   1                 config write strobe
//   i_cfg_ch      in   CH_W              channel index for write; CH_W = max(1,$clog2(N_CH))
//   i_cfg_period  in   PERIOD_W          period in base ticks
//   i_cfg_mode    in   1                 0 = one-shot, 1 = periodic
//   i_start       in   N_CH              per-channel start/restart pulse
//   i_stop        in   N_CH              per-channel stop pulse
//   o_tick        out  1                 base tick enable, 1 cycle every DIV cycles
//   o_busy        out  N_CH              channel armed
//   o_fire        out  N_CH              channel expiry enable, 1 cycle
// BEHAVIOUR
//   Reset: async assert clears all state. o_tick=0, o_busy=0, o_fire=0.
//     Prescaler=0, all period regs=0, all mode regs=0. Release is synchronous to i_clk.
//   Prescaler: free-running 0..DIV-1. o_tick is registered, high in the cycle after the count reaches DIV-1.
//   Config write: period/mode regs of i_cfg_ch update on the edge. i_cfg_ch >= N_CH is ignored.
//     A running countdown is not disturbed; the new values apply at the next load/reload.
//   Channel FSM: IDLE -> ARMED on start; ARMED -> IDLE on stop or one-shot expiry.
//   Start (IDLE or ARMED): count <= period, state ARMED, o_busy=1 from the next cycle.
//     Start while ARMED restarts the count.
//   Start with effective period 0: ignored. The channel stays in, or keeps, its current state.
//   Cfg write + start, same channel, same cycle: the start uses i_cfg_period/i_cfg_mode (bypass).
//   Countdown: in ARMED, each o_tick cycle decrements count. An o_tick in the start cycle is not counted.
//   Expiry: o_tick with count==1 -> o_fire registered high for exactly one cycle, the cycle after that o_tick.
//     Periodic: count <= current period reg, stays ARMED, no gap tick.
//     One-shot: IDLE; o_busy falls in the same cycle o_fire rises.
//   Latency: first o_fire follows start by exactly `period` o_tick pulses, plus 1 cycle.
//   Priority per channel, same cycle: stop > start > expiry.
//     Stop coinciding with expiry: no fire, IDLE.
//     Start coinciding with expiry: restart, no fire.
//   Channels are independent; any number may fire in the same cycle (o_fire bits simultaneously set).
//   Count arithmetic is unsigned PERIOD_W; it never underflows because zero is never loaded.
// STRUCTURE
//   Package tick_sched_pkg: chan_state_t {IDLE, ARMED}, mode constants MODE_ONESHOT=0 / MODE_PERIODIC=1.
//     Also holds a DIV/width helper function.
//   Sub-module tick_sched_channel: one FSM + period/mode regs + countdown, instantiated N_CH times.
//     Prescaler and config decode stay in tick_scheduler.
//   Elaboration check: DIV >= 2 and N_CH within 1..16, else $error.
// TESTING  (I_CLK_FRQ=100, TICK_FRQ=10 -> DIV=10; N_CH=4; PERIOD_W=8)
//   1 Reset, idle 50 cycles -> o_tick every 10th cycle, o_busy=0, o_fire=0 throughout.
//   2 ch0 cfg period=3, one-shot; start -> o_fire[0] exactly once, the cycle after the 3rd o_tick.
//     o_busy[0] drops the same cycle; no further fires over 200 cycles.
//   3 ch1 periodic period=2, ch2 periodic period=5, started in the same cycle.
//     -> fires every 20 and 50 cycles respectively; at 100 cycles both bits set in one cycle.
//   4 ch3 periodic period=1; i_stop[3] in the expiring o_tick cycle -> no o_fire[3], o_busy[3]=0.
//     Repeat with i_start[3] instead -> no fire, next fire 10 cycles later.
//   5 ch0 period reg=0, start -> ignored, o_busy[0] stays 0.
//     Same cycle cfg_we(ch0, period=4) + start -> first fire after 4 ticks.
//     Cfg write to ch0 mid-count -> current expiry unchanged; new period used at reload.
//   6 Assert i_rst asynchronously mid-count (between edges) -> o_busy/o_fire/o_tick 0 immediately.
//     After release, no fires until a new start.

Source files
------------

// File: rtl/tick_sched_pkg.sv
// Shared types and elaboration helpers for the tick scheduler.
package tick_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } chan_state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  function automatic int unsigned calc_div(input int unsigned clk_frq,
                                           input int unsigned tick_frq);
    return clk_frq / tick_frq;
  endfunction

  // Index/counter width that never collapses to zero bits.
  function automatic int unsigned min_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_sched_channel.sv
// One timer channel: period/mode config, countdown on the shared base tick,
// and a one-cycle fire enable in one-shot or periodic mode.
module tick_sched_channel
  import tick_sched_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_tick,
  input  logic                i_cfg_we,
  input  logic [PERIOD_W-1:0] i_cfg_period,
  input  logic                i_cfg_mode,
  input  logic                i_start,
  input  logic                i_stop,
  output logic                o_busy,
  output logic                o_fire
);

  chan_state_t         state_q, state_d;
  logic [PERIOD_W-1:0] count_q, count_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                mode_q, mode_d;
  logic                run_mode_q, run_mode_d;
  logic                fire_q, fire_d;
  logic [PERIOD_W-1:0] eff_period;
  logic                eff_mode;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    period_d   = period_q;
    mode_d     = mode_q;
    run_mode_d = run_mode_q;
    fire_d     = 1'b0;

    // Same-cycle config write feeds a start directly.
    eff_period = i_cfg_we ? i_cfg_period : period_q;
    eff_mode   = i_cfg_we ? i_cfg_mode   : mode_q;

    if (i_cfg_we) begin
      period_d = i_cfg_period;
      mode_d   = i_cfg_mode;
    end

    if (i_stop) begin
      state_d = IDLE;
    end else if (i_start && (eff_period != '0)) begin
      state_d    = ARMED;
      count_d    = eff_period;
      run_mode_d = eff_mode;
    end else if ((state_q == ARMED) && i_tick) begin
      if (count_q == PERIOD_W'(1)) begin
        fire_d = 1'b1;
        // A zero period reg cannot be reloaded, so a periodic run ends there.
        if ((run_mode_q == MODE_PERIODIC) && (period_q != '0)) begin
          count_d    = period_q;
          run_mode_d = mode_q;
        end else begin
          state_d = IDLE;
        end
      end else begin
        count_d = count_q - PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      period_q   <= '0;
      mode_q     <= MODE_ONESHOT;
      run_mode_q <= MODE_ONESHOT;
      fire_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      period_q   <= period_d;
      mode_q     <= mode_d;
      run_mode_q <= run_mode_d;
      fire_q     <= fire_d;
    end
  end

  assign o_busy = (state_q == ARMED);
  assign o_fire = fire_q;

endmodule

// File: rtl/tick_scheduler.sv
// Shared prescaled base tick plus N_CH independent one-shot/periodic timers.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter  int unsigned I_CLK_FRQ = 100_000_000,
  parameter  int unsigned TICK_FRQ  = 1_000,
  parameter  int unsigned N_CH      = 4,
  parameter  int unsigned PERIOD_W  = 16,
  localparam int unsigned CH_W      = min_width(N_CH)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cfg_we,
  input  logic [CH_W-1:0]     i_cfg_ch,
  input  logic [PERIOD_W-1:0] i_cfg_period,
  input  logic                i_cfg_mode,
  input  logic [N_CH-1:0]     i_start,
  input  logic [N_CH-1:0]     i_stop,
  output logic                o_tick,
  output logic [N_CH-1:0]     o_busy,
  output logic [N_CH-1:0]     o_fire
);

  localparam int unsigned DIV  = calc_div(I_CLK_FRQ, TICK_FRQ);
  localparam int unsigned PS_W = (DIV >= 2) ? $clog2(DIV) : 1;

  if ((DIV < 2) || (N_CH < 1) || (N_CH > 16)) begin : g_bad_cfg
    $error("tick_scheduler: DIV must be >= 2 and N_CH within 1..16");
  end

  logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;
  logic            tick_q, tick_d;

  always_comb begin
    tick_d   = (ps_cnt_q == PS_W'(DIV - 1));
    ps_cnt_d = tick_d ? '0 : ps_cnt_q + PS_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ps_cnt_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      ps_cnt_q <= ps_cnt_d;
      tick_q   <= tick_d;
    end
  end

  assign o_tick = tick_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic cfg_sel;
    assign cfg_sel = i_cfg_we && (i_cfg_ch == CH_W'(g));

    tick_sched_channel #(
      .PERIOD_W (PERIOD_W)
    ) u_channel (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_tick       (tick_q),
      .i_cfg_we     (cfg_sel),
      .i_cfg_period (i_cfg_period),
      .i_cfg_mode   (i_cfg_mode),
      .i_start      (i_start[g]),
      .i_stop       (i_stop[g]),
      .o_busy       (o_busy[g]),
      .o_fire       (o_fire[g])
    );
  end

endmodule
